// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: channel mode
// encodings, PWM width and the duty value every channel starts with.
// Optional PWM dimming is enabled by defining LED_BLINK_PWM_EN.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    localparam int PWM_W = 8;
    localparam logic [PWM_W-1:0] DUTY_RST = 8'hFF;

    // LED level a channel comes out of reset with: a one-shot cannot be
    // "in progress" straight out of reset, so only ON and BLINK light up.
    function automatic logic reset_lit(mode_e m);
        return (m == MODE_ON) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: mode, half-period, tick counter, LED state and one-shot
// busy flag. Advances only on the shared prescaler tick; a config write
// always has priority over a tick in the same cycle.
// With LED_BLINK_PWM_EN defined the channel also stores a duty value and
// gates its LED level with the shared PWM counter through one extra register.
module led_blink_channel
    import led_blink_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEFAULT_MODE = 2,
    parameter int DEFAULT_HALF = 5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             we_i,
    input  logic [1:0]       mode_i,
    input  logic [CNT_W-1:0] half_i,
`ifdef LED_BLINK_PWM_EN
    input  logic [PWM_W-1:0] duty_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
`endif
    output logic             led_o,
    output logic             busy_o
);

    localparam mode_e            RST_MODE = mode_e'(2'(DEFAULT_MODE));
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
    localparam logic             RST_LIT  = reset_lit(RST_MODE);

    mode_e            mode_q;
    logic [CNT_W-1:0] half_q;
    logic [CNT_W-1:0] cnt_q;
    logic             state_q;
    logic             busy_q;
    mode_e            wr_mode;

    assign wr_mode = mode_e'(mode_i);

    // Channel FSM: a write reloads the channel, otherwise a tick advances
    // BLINK/ONESHOT timing; OFF and ON simply hold their counter.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= RST_MODE;
            half_q  <= RST_HALF;
            cnt_q   <= '0;
            state_q <= RST_LIT;
            busy_q  <= 1'b0;
        end else if (we_i) begin
            mode_q  <= wr_mode;
            half_q  <= half_i;
            cnt_q   <= '0;
            state_q <= (wr_mode != MODE_OFF);
            busy_q  <= (wr_mode == MODE_ONESHOT);
        end else if (tick_i) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (cnt_q == half_q) begin
                        state_q <= ~state_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                MODE_ONESHOT: begin
                    if (cnt_q == half_q) begin
                        state_q <= 1'b0;
                        busy_q  <= 1'b0;
                        mode_q  <= MODE_OFF;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    // OFF / ON: level fixed at write time, counter held
                end
            endcase
        end
    end

    assign busy_o = busy_q;

`ifdef LED_BLINK_PWM_EN
    logic [PWM_W-1:0] duty_q;
    logic             led_q;

    // Per-channel duty register, reloaded together with mode and half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q <= DUTY_RST;
        end else if (we_i) begin
            duty_q <= duty_i;
        end
    end

    // PWM gate: LED lit only while the shared counter is below the duty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= RST_LIT;
        end else begin
            led_q <= state_q & (pwm_cnt_i < duty_q);
        end
    end

    assign led_o = led_q;
`else
    assign led_o = state_q;
`endif

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED blinker top: shared timing prescaler, config-channel
// decode and one led_blink_channel per LED. All LED/busy outputs are
// registered inside the channels, so no input reaches a pin combinationally.
// Define LED_BLINK_PWM_EN to add the cfg_duty port and PWM dimming.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int PRESCALE     = 4800,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_MODE = 2,
    parameter int DEFAULT_HALF = 5000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef LED_BLINK_PWM_EN
    input  logic [PWM_W-1:0]  cfg_duty,
`endif
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] busy
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;
    logic            tick;

    // Prescaler next state: tick on the last count, then wrap to zero.
    // NOTE: every always_comb output is assigned on every path, so no latch
    // can be inferred.
    always_comb begin
        tick = (ps_q == PS_LAST);
        ps_d = tick ? '0 : ps_q + PS_W'(1);
    end

    // Prescaler register; config writes never disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

`ifdef LED_BLINK_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;

    // Free-running PWM phase counter shared by all channels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
        end
    end
`endif

    // One channel per LED; an out-of-range cfg_ch matches no channel and is
    // therefore ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_ch;

        assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

        led_blink_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_MODE (DEFAULT_MODE),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (tick),
            .we_i      (we_ch),
            .mode_i    (cfg_mode),
            .half_i    (cfg_half),
`ifdef LED_BLINK_PWM_EN
            .duty_i    (cfg_duty),
            .pwm_cnt_i (pwm_cnt_q),
`endif
            .led_o     (led[i]),
            .busy_o    (busy[i])
        );
    end

endmodule

// File: tb/tb_led_blink_multi.sv
// Self-checking bench for led_blink_multi. Three channels are used so that
// cfg_ch is two bits wide and index 3 is a genuine out-of-range channel.
// Default build: a table of hand-derived vectors, an asynchronous-reset
// sequence, then random config writes checked against a timing model that
// derives each LED from the number of ticks elapsed since its last write.
// With LED_BLINK_PWM_EN: duty-cycle counting over full PWM periods.
module tb_led_blink_multi;

    localparam int NUM_CH   = 3;
    localparam int CH_W     = 2;
    localparam int PRESCALE = 4;
    localparam int CNT_W    = 16;
    localparam int DEF_MODE = 2;
    localparam int DEF_HALF = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [CNT_W-1:0]  cfg_half = '0;
`ifdef LED_BLINK_PWM_EN
    logic [7:0]        cfg_duty = 8'hFF;
`endif
    logic [NUM_CH-1:0] led;
    logic [NUM_CH-1:0] busy;

    int total = 0;
    int bad   = 0;
    int edges = 0;   // clock edges since reset release

    // Model: per channel, the edge index of its last accepted write
    // (-1 = reset) plus the mode and half-period it was given.
    int m_wk   [NUM_CH];
    int m_mode [NUM_CH];
    int m_half [NUM_CH];

    always #5 clk = ~clk;

    led_blink_multi #(
        .NUM_CH       (NUM_CH),
        .PRESCALE     (PRESCALE),
        .CNT_W        (CNT_W),
        .DEFAULT_MODE (DEF_MODE),
        .DEFAULT_HALF (DEF_HALF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
`ifdef LED_BLINK_PWM_EN
        .cfg_duty (cfg_duty),
`endif
        .led      (led),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_wk[c]   = -1;
            m_mode[c] = DEF_MODE;
            m_half[c] = DEF_HALF;
        end
    endtask

    // Expected outputs after the most recent edge (index edges-1). Ticks fall
    // on edges with index mod PRESCALE == PRESCALE-1; a tick on the write
    // edge itself is discarded, so only edges strictly after it count.
    task automatic model_expect(output logic [NUM_CH-1:0] el, output logic [NUM_CH-1:0] eb);
        el = '0;
        eb = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int n;
            int h1;
            n  = edges / PRESCALE - (m_wk[c] + 1) / PRESCALE;
            h1 = m_half[c] + 1;
            case (m_mode[c])
                0: el[c] = 1'b0;
                1: el[c] = 1'b1;
                2: el[c] = ((n / h1) % 2) == 0;
                default: begin
                    el[c] = (n < h1);
                    eb[c] = (n < h1);
                end
            endcase
        end
    endtask

    // Drive a write for the next edge (called at a negedge).
    task automatic drive_write(input int ch, input int mode, input int half);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_mode = 2'(mode);
        cfg_half = CNT_W'(half);
        if (ch < NUM_CH) begin
            m_wk[ch]   = edges;
            m_mode[ch] = mode;
            m_half[ch] = half;
        end
    endtask

    // Advance n edges, ending at a negedge; a write lasts exactly one edge.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            cfg_we = 1'b0;
        end
    endtask

    task automatic apply_reset();
        cfg_we = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        edges = 0;
        model_reset();
    endtask

    typedef struct {
        int              adv;
        bit              we;
        int              ch;
        int              mode;
        int              half;
        logic [NUM_CH-1:0] led;
        logic [NUM_CH-1:0] busy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int adv, input bit we, input int ch, input int mode,
                                input int half, input logic [NUM_CH-1:0] l,
                                input logic [NUM_CH-1:0] b);
        vec_t v;
        v.adv = adv; v.we = we; v.ch = ch; v.mode = mode; v.half = half;
        v.led = l; v.busy = b;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] el;
        logic [NUM_CH-1:0] eb;

        apply_reset();

`ifdef LED_BLINK_PWM_EN
        begin
            int cnt;
            check("pwm_reset_led", led, 3'b111);
            check("pwm_reset_busy", busy, 3'b000);

            cfg_duty = 8'h40;
            drive_write(0, 1, 0);
            step(4);
            check("pwm_on_busy", busy[0], 1'b0);
            cnt = 0;
            for (int k = 0; k < 256; k++) begin
                step(1);
                cnt += int'(led[0]);
            end
            check("pwm_duty40_count", cnt, 64);

            cfg_duty = 8'h00;
            drive_write(0, 1, 0);
            step(4);
            cnt = 0;
            for (int k = 0; k < 256; k++) begin
                step(1);
                cnt += int'(led[0]);
            end
            check("pwm_duty0_count", cnt, 0);

            cfg_duty = 8'hFF;
            drive_write(0, 1, 0);
            step(4);
            cnt = 0;
            for (int k = 0; k < 256; k++) begin
                step(1);
                cnt += int'(led[0]);
            end
            check("pwm_dutyff_count", cnt, 255);

            drive_write(1, 3, 1);
            step(1);
            check("pwm_oneshot_busy", busy[1], 1'b1);
        end
`else
        // {edges to advance, write?, ch, mode, half, expected led, expected busy}
        // led bits are {ch2, ch1, ch0}; ticks land on edges 3, 7, 11, ...
        add( 0, 0, 0, 0, 0, 3'b111, 3'b000);  // reset state
        add(11, 0, 0, 0, 0, 3'b111, 3'b000);  // up to edge 10: still lit
        add( 1, 0, 0, 0, 0, 3'b000, 3'b000);  // edge 11: third tick toggles all
        add(12, 0, 0, 0, 0, 3'b111, 3'b000);  // edge 23: toggle back
        add( 1, 1, 1, 0, 2, 3'b101, 3'b000);  // ch1 OFF one cycle later
        add(10, 0, 0, 0, 0, 3'b101, 3'b000);  // up to edge 34
        add( 1, 0, 0, 0, 0, 3'b000, 3'b000);  // edge 35: ch0, ch2 toggle
        add( 1, 1, 0, 3, 1, 3'b001, 3'b001);  // ch0 ONESHOT half=1
        add( 6, 0, 0, 0, 0, 3'b001, 3'b001);  // still lit through edge 42
        add( 1, 0, 0, 0, 0, 3'b000, 3'b000);  // edge 43: second tick ends it
        add( 8, 0, 0, 0, 0, 3'b100, 3'b000);  // ch0 stays OFF; ch2 toggled at 47
        add( 1, 1, 1, 2, 0, 3'b110, 3'b000);  // ch1 BLINK half=0
        add( 2, 0, 0, 0, 0, 3'b110, 3'b000);  // up to edge 54
        add( 1, 1, 0, 2, 0, 3'b101, 3'b000);  // write on tick edge 55: ch0 lit, ch1 toggles
        add( 3, 0, 0, 0, 0, 3'b101, 3'b000);  // up to edge 58
        add( 1, 0, 0, 0, 0, 3'b010, 3'b000);  // edge 59: all three toggle
        add( 1, 1, 3, 3, 5, 3'b010, 3'b000);  // cfg_ch=3 ignored
        add( 3, 0, 0, 0, 0, 3'b001, 3'b000);  // edge 63: ch0, ch1 toggle

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we) drive_write(tbl[i].ch, tbl[i].mode, tbl[i].half);
            step(tbl[i].adv);
            check($sformatf("vec%0d_led", i), led, tbl[i].led);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
        end

        // Asynchronous reset in the middle of a one-shot and blinking.
        drive_write(0, 3, 3);
        step(1);
        check("pre_reset_busy", busy, 3'b001);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_led", led, 3'b111);
        check("async_reset_busy", busy, 3'b000);
        @(negedge clk);
        @(negedge clk);
        check("held_reset_led", led, 3'b111);
        reset = 1'b0;
        edges = 0;
        model_reset();
        step(11);
        check("post_reset_led_a", led, 3'b111);
        step(1);
        check("post_reset_led_b", led, 3'b000);

        // Random config traffic against the elapsed-tick model.
        apply_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 5) == 0) begin
                drive_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)));
            end
            step(1);
            model_expect(el, eb);
            check($sformatf("rand_led@%0d", cyc), led, el);
            check($sformatf("rand_busy@%0d", cyc), busy, eb);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
